// File: rtl/ro_pkg.sv
// Shared types and default sizes for the gated event counter.
package ro_pkg;

  localparam int RO_WIDTH  = 16;
  localparam int RO_GATE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_HOLD = 2'd2
  } ro_state_t;

endpackage

// File: rtl/ro_sat_counter.sv
// Saturating event accumulator: counts up on inc, sticks at all-ones.
module ro_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  assign sat = &count;

  // Clear has priority over increment; increment is blocked at saturation.
  always_ff @(posedge clk) begin
    if (!rst_n)           count <= '0;
    else if (clr)         count <= '0;
    else if (inc && !sat) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/ro_gated_counter.sv
// Gated event counter: counts evt strobes over a gate_len-cycle window and
// holds the result until the consumer takes it.
module ro_gated_counter
  import ro_pkg::*;
#(
  parameter int WIDTH  = RO_WIDTH,
  parameter int GATE_W = RO_GATE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              evt,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              count_valid,
  input  logic              count_ready,
  output logic              busy,
  output logic              overflow
);

  ro_state_t         state, state_n;
  logic [GATE_W-1:0] gate_cnt, gate_cnt_n;
  logic              accept;
  logic              acc_clr, acc_inc, acc_sat;

  // Accumulator is cleared on a new measurement or on abort; it only
  // counts while the gate is open.
  assign acc_clr = accept | abort;
  assign acc_inc = (state == S_GATE) & evt & ~abort;

  ro_sat_counter #(.WIDTH(WIDTH)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .inc   (acc_inc),
    .count (count),
    .sat   (acc_sat)
  );

  // State and remaining-gate-cycle registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gate_cnt <= '0;
    end else begin
      state    <= state_n;
      gate_cnt <= gate_cnt_n;
    end
  end

  // Next-state: gate_cnt counts down remaining sampled cycles, so the
  // largest gate_len never wraps. Abort overrides everything.
  always_comb begin
    state_n    = state;
    gate_cnt_n = gate_cnt;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          gate_cnt_n = gate_len;
          state_n    = (gate_len != '0) ? S_GATE : S_HOLD;
        end
      end
      S_GATE: begin
        gate_cnt_n = gate_cnt - GATE_W'(1);
        if (gate_cnt == GATE_W'(1)) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (count_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n    = S_IDLE;
      gate_cnt_n = '0;
      accept     = 1'b0;
    end
  end

  // Registered status outputs, decoded from the next state so they line
  // up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= (state_n == S_HOLD);
      busy        <= (state_n != S_IDLE);
    end
  end

  // Sticky overflow: set when an increment is swallowed by saturation.
  always_ff @(posedge clk) begin
    if (!rst_n)                  overflow <= 1'b0;
    else if (acc_clr)            overflow <= 1'b0;
    else if (acc_inc && acc_sat) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_ro_gated_counter.sv
// Directed bench for ro_gated_counter: a 16-bit and a 4-bit instance share
// the same stimulus; the narrow one exercises saturation.
module tb_ro_gated_counter;

  logic        clk = 1'b0;
  logic        rst_n, start, evt, abort, count_ready;
  logic [15:0] gate_len;
  logic [15:0] count16;
  logic [3:0]  count4;
  logic        valid16, busy16, ovf16;
  logic        valid4, busy4, ovf4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ro_gated_counter #(.WIDTH(16), .GATE_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len), .evt(evt),
    .abort(abort), .count(count16), .count_valid(valid16),
    .count_ready(count_ready), .busy(busy16), .overflow(ovf16)
  );

  ro_gated_counter #(.WIDTH(4), .GATE_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len), .evt(evt),
    .abort(abort), .count(count4), .count_valid(valid4),
    .count_ready(count_ready), .busy(busy4), .overflow(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; evt = 1'b0; abort = 1'b0;
    count_ready = 1'b0; gate_len = 16'd0;
    #1;
    tick(); tick();
    chk("rst_count",    32'(count16), 0);
    chk("rst_valid",    32'(valid16), 0);
    chk("rst_busy",     32'(busy16),  0);
    chk("rst_overflow", 32'(ovf16),   0);
    rst_n = 1'b1;
    tick();

    // gate_len=10, evt constant; gate_len changed after acceptance
    gate_len = 16'd10; evt = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; gate_len = 16'd3;
    chk("g10_busy_e0",  32'(busy16),  1);
    chk("g10_valid_e0", 32'(valid16), 0);
    for (int i = 0; i < 9; i++) tick();
    chk("g10_valid_e9", 32'(valid16), 0);
    chk("g10_count_e9", 32'(count16), 9);
    tick();
    chk("g10_valid",    32'(valid16), 1);
    chk("g10_count",    32'(count16), 10);
    chk("g10_overflow", 32'(ovf16),   0);
    chk("g10_count4",   32'(count4),  10);
    // hold with ready low, start pulse ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      gate_len = 16'd2;
      tick();
      chk("hold_valid", 32'(valid16), 1);
      chk("hold_count", 32'(count16), 10);
    end
    start = 1'b0;
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;
    chk("rel_valid", 32'(valid16), 0);
    chk("rel_busy",  32'(busy16),  0);
    chk("rel_count", 32'(count16), 10);
    tick();
    chk("idle_count", 32'(count16), 10);

    // gate_len=8, toggling evt
    gate_len = 16'd8; start = 1'b1; evt = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      evt = (i % 2 == 0);
      tick();
    end
    evt = 1'b0;
    chk("tog_valid", 32'(valid16), 1);
    chk("tog_count", 32'(count16), 4);
    count_ready = 1'b1; tick(); count_ready = 1'b0;

    // gate_len=20 saturates the 4-bit instance
    gate_len = 16'd20; start = 1'b1; evt = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_valid4",   32'(valid4), 1);
    chk("sat_count4",   32'(count4), 15);
    chk("sat_ovf4",     32'(ovf4),   1);
    chk("sat_count16",  32'(count16), 20);
    chk("sat_ovf16",    32'(ovf16),  0);
    count_ready = 1'b1; tick(); count_ready = 1'b0;
    chk("idle_ovf4", 32'(ovf4), 1);
    gate_len = 16'd2; start = 1'b1; evt = 1'b0;
    tick();
    start = 1'b0;
    chk("restart_ovf4",   32'(ovf4),   0);
    chk("restart_count4", 32'(count4), 0);
    tick(); tick();
    chk("restart_valid4", 32'(valid4), 1);
    count_ready = 1'b1; tick(); count_ready = 1'b0;

    // gate_len=0
    gate_len = 16'd0; start = 1'b1; evt = 1'b1;
    tick();
    start = 1'b0;
    chk("g0_valid", 32'(valid16), 1);
    chk("g0_count", 32'(count16), 0);
    chk("g0_busy",  32'(busy16),  1);
    count_ready = 1'b1; tick(); count_ready = 1'b0;
    chk("g0_idle_busy", 32'(busy16), 0);

    // reset at gate cycle 3 of 10, with start held high
    gate_len = 16'd10; start = 1'b1; evt = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_count", 32'(count16), 3);
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    chk("mrst_count", 32'(count16), 0);
    chk("mrst_valid", 32'(valid16), 0);
    chk("mrst_busy",  32'(busy16),  0);
    chk("mrst_ovf",   32'(ovf16),   0);
    gate_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("fresh_count_e0", 32'(count16), 0);
    tick();
    chk("fresh_count_e1", 32'(count16), 1);
    tick(); tick(); tick();
    chk("fresh_valid", 32'(valid16), 1);
    chk("fresh_count", 32'(count16), 4);

    // abort with count_ready in HOLD
    abort = 1'b1; count_ready = 1'b1;
    tick();
    abort = 1'b0; count_ready = 1'b0;
    chk("abort_valid", 32'(valid16), 0);
    chk("abort_count", 32'(count16), 0);
    chk("abort_busy",  32'(busy16),  0);

    // abort wins over start in IDLE
    abort = 1'b1; start = 1'b1; gate_len = 16'd5;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy16), 0);

    // abort mid-gate
    gate_len = 16'd6; start = 1'b1; evt = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_gate_count", 32'(count16), 0);
    chk("abort_gate_busy",  32'(busy16),  0);
    tick(); tick(); tick(); tick(); tick();
    chk("abort_gate_valid", 32'(valid16), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_gated_counter.md
RO_GATED_COUNTER -- requirements
Module: ro_gated_counter

Interface
REQ-001 Parameter WIDTH, default 16: event-count width.
REQ-002 Parameter GATE_W, default 16: gate-length width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request a measurement; accepted only in IDLE.
REQ-006 gate_len  input  GATE_W  measurement window in clk cycles; sampled on start acceptance.
REQ-007 evt  input  1  clk-synchronous event strobe; counts 1 per cycle high.
REQ-008 abort  input  1  cancel the measurement in progress.
REQ-009 count  output  WIDTH  accumulated event count.
REQ-010 count_valid  output  1  result available.
REQ-011 count_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high in GATE and HOLD.
REQ-013 overflow  output  1  accumulator saturated during the current/last window.

Function
REQ-014 FSM states SHALL be IDLE, GATE, HOLD.
REQ-015 IDLE with start=1 and abort=0 SHALL latch gate_len, clear count and overflow, and go to GATE if gate_len!=0, else to HOLD with count=0.
REQ-016 In GATE, evt SHALL be sampled for exactly gate_len consecutive cycles, starting with the first cycle after start acceptance.
REQ-017 In GATE, count SHALL increment by 1 per cycle with evt=1.
REQ-018 At the all-ones value, count SHALL hold instead of incrementing.
REQ-019 overflow SHALL set, sticky until the next accepted start, when an increment is blocked by saturation.
REQ-020 After the gate_len-th sampled cycle, the FSM SHALL enter HOLD with count including that cycle's evt.
REQ-021 count_valid SHALL equal 1 exactly in HOLD.
REQ-022 In HOLD, count and overflow SHALL be stable.
REQ-023 In HOLD with count_ready=1, the FSM SHALL return to IDLE on that edge.
REQ-024 count SHALL retain its value in IDLE until the next accepted start.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 gate_len changes after acceptance SHALL be ignored.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge with count=0 and overflow=0.
REQ-028 abort SHALL win over simultaneous start or count_ready.
REQ-029 busy SHALL be high in GATE and HOLD and low in IDLE.
REQ-030 Result latency SHALL be gate_len+1 cycles from the start edge to count_valid=1, or 1 cycle when gate_len=0.
REQ-031 The maximum gate_len, 2^GATE_W-1, SHALL be supported without wrap of the gate down-counter.

Reset
REQ-032 With rst_n=0 at a clk edge, state SHALL become IDLE.
REQ-033 With rst_n=0 at a clk edge, count=0, count_valid=0, busy=0, overflow=0 and the gate counter=0, regardless of other inputs.
REQ-034 Reset SHALL take priority over abort and start.
REQ-035 Reset mid-GATE or mid-HOLD SHALL discard the measurement.

Structure
REQ-036 The state encoding type and default WIDTH/GATE_W constants SHALL live in shared package ro_pkg.
REQ-037 The saturating accumulator SHALL be sub-module ro_sat_counter (inputs: clk, rst_n, clr, inc; outputs: count, sat).
REQ-038 Outputs SHALL be registered.
REQ-039 The block SHALL have no combinational path from evt to any output.

Verification
REQ-040 WIDTH=16, gate_len=10, evt=1 constantly -> count=10, overflow=0, count_valid rises 11 cycles after start.
REQ-041 gate_len=8, evt toggling 1,0,1,0... from the first gate cycle -> count=4.
REQ-042 WIDTH=4, gate_len=20, evt=1 -> count=15, overflow=1.
REQ-042a Next start in REQ-042 setup -> overflow clears to 0.
REQ-043 gate_len=0 -> count_valid=1 one cycle after start, count=0.
REQ-043a count_ready low 5 cycles while in HOLD -> count_valid held and count stable.
REQ-043b start pulsed during HOLD -> ignored.
REQ-044 rst_n=0 for one edge at gate cycle 3 of 10 -> next cycle all outputs 0, state IDLE.
REQ-044a Following start -> fresh count from 0.
REQ-045 abort together with count_ready in HOLD -> IDLE, count=0, count_valid=0.
